dff_stim_sig: RTL and testbench
===============================

Name: dff_stim_sig

Overview:
- Stimulus/response stage for the CC_DFF verification test cases.
- Upstream role: drives `d`/`en`/`sr` into a bank of flip-flops under test from a pseudo-random LFSR sequence.
- Downstream role: compacts the bank's `q` vector every cycle into a 32-bit MISR signature, so on-silicon results can be compared to simulation with one word.
- Sits in the test-case top between the pins and the DFF array; the DFF array shares `clk`.

Parameters:
- WIDTH, 64, width of the DUT `q` vector; must be a multiple of 32.
- STEPS, 256, number of RUN cycles (≥1).
- SETTLE_CYC, 2, idle-stimulus cycles before RUN (≥1).
- SEED, 16'hACE1, stimulus LFSR seed; a value of 0 is replaced by 16'h0001.
- POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  single clock, rising edge; also clocks the DFF bank.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sequence.
- q  in  WIDTH  outputs of the DFF bank under test.
- d  out  1  data stimulus to the DFF bank.
- en  out  1  enable stimulus.
- sr  out  1  set/reset stimulus.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  high in DONE; held until next start or rst.
- signature  out  32  MISR result.

Behaviour:
- Reset is synchronous active-high (`rst`) on `clk`; one clock domain only.
- On `rst`: state=IDLE; `d`=`en`=`sr`=0; `busy`=0; `done`=0; `signature`=0; LFSR=SEED.
- All outputs are registered.

FSM states: IDLE, SETTLE, RUN, DRAIN, DONE.
- IDLE -> SETTLE when `start`=1.
  - On this transition: LFSR<=SEED; `signature`<=32'hFFFFFFFF; `busy`<=1; `done`<=0.
- SETTLE: `d`=`en`=`sr`=0 for SETTLE_CYC cycles, then -> RUN. No compaction.
- RUN: STEPS cycles, then -> DRAIN.
  - Each RUN cycle presents the current LFSR value: `en`=lfsr[0], `sr`=lfsr[1]&lfsr[2], `d`=lfsr[3].
  - The LFSR then advances: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, shift right, mask 16'hB400.
  - The first RUN cycle therefore shows SEED bits.
- DRAIN: 1 cycle; `d`=`en`=`sr`=0; -> DONE.
- DONE: `busy`=0, `done`=1, `signature` frozen; -> SETTLE on `start` (restart exactly as from IDLE).

Compaction:
- Compaction enable `cmp` = (state==RUN) delayed one cycle. This covers the one-cycle DFF latency, so exactly STEPS samples are taken; the last sample lands in the DRAIN cycle.
- fold = XOR of all WIDTH/32 32-bit slices of `q`.
- When `cmp`: `signature` <= ({sig[30:0],1'b0} ^ (sig[31] ? POLY : 0)) ^ fold.

Boundary conditions:
- `start` while `busy`: ignored; sequence and signature unaffected.
- `start` coincident with `rst`: `rst` wins; stays IDLE.
- `rst` mid-sequence: next cycle all outputs at reset values; no partial `done`.
- `q` is sampled unqualified; X on `q` propagates to `signature`, which the bench must flag.
- Total `busy` cycles = SETTLE_CYC+STEPS+1.

Optional Feature:
- Macro SIG_COMPARE_EN.
- When defined:
  - Extra parameter GOLDEN (default 32'h0).
  - Extra output `pass` (1 bit), registered.
  - `pass` <= (`signature`==GOLDEN) on entry to DONE.
  - `pass` is cleared by `rst` and on start.
- When undefined: no GOLDEN, no `pass` port; the rest is identical.

Test Plan:
- Reset: assert `rst` 2 cycles -> `d`=`en`=`sr`=`busy`=`done`=0, `signature`=32'h0; hold `start`=1 with `rst`=1 -> stays IDLE.
- Single step: STEPS=1, SETTLE_CYC=2, `q`=0, pulse `start` -> `busy` high exactly 4 cycles, then `done`=1, `signature`=32'hFB3EE249.
- Fold check: STEPS=1, `q`=64'h0000_0001_0000_0000 -> `signature`=32'hFB3EE248; `q`=64'h0000_0001_0000_0001 -> 32'hFB3EE249 (slices cancel).
- Stimulus: SEED=16'hACE1 -> first RUN cycle `en`=1, `sr`=0, `d`=0; the next 8 RUN cycles match the reference LFSR model bit-for-bit; SEED=0 behaves as 16'h0001.
- Robustness: pulse `start` mid-RUN -> signature identical to an undisturbed run; assert `rst` mid-RUN -> IDLE with zeroed outputs next cycle, then a new `start` gives a full-length correct run.
- SIG_COMPARE_EN: GOLDEN=32'hFB3EE249, STEPS=1, `q`=0 -> `pass`=1 in DONE; GOLDEN=0 -> `pass`=0.

Source files
------------

// File: rtl/dff_stim_sig_if.sv
// Bus between the DFF stimulus/signature stage and its test-case top.
// The `pass` signal exists only when SIG_COMPARE_EN is defined.
interface dff_stim_sig_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] q;
  logic             d;
  logic             en;
  logic             sr;
  logic             busy;
  logic             done;
  logic [31:0]      signature;
`ifdef SIG_COMPARE_EN
  logic             pass;
`endif

  modport slave (
    input  start, q,
    output d, en, sr, busy, done, signature
`ifdef SIG_COMPARE_EN
    , output pass
`endif
  );

  modport master (
    output start, q,
    input  d, en, sr, busy, done, signature
`ifdef SIG_COMPARE_EN
    , input pass
`endif
  );
endinterface

// File: rtl/dff_stim_sig.sv
// LFSR stimulus generator and MISR response compactor for a DFF bank under test.
// Optional macro SIG_COMPARE_EN adds GOLDEN parameter and registered `pass` output.
module dff_stim_sig #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STEPS      = 256,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [31:0] POLY       = 32'h04C11DB7
`ifdef SIG_COMPARE_EN
  , parameter logic [31:0] GOLDEN   = 32'h0
`endif
) (
  input logic           clk,
  input logic           rst,
  dff_stim_sig_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETTLE, RUN, DRAIN, DONE} state_e;

  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] RUN_LAST    = 32'(STEPS - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] sig_q, sig_d;
  logic        cmp_q, cmp_d;
  logic        d_q, d_d;
  logic        en_q, en_d;
  logic        sr_q, sr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] fold;
  logic        start_ok;
`ifdef SIG_COMPARE_EN
  logic        pass_q, pass_d;
`endif

  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (cnt_q == SETTLE_LAST) state_d = RUN;
      RUN:     if (cnt_q == RUN_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.start) state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < WIDTH / 32; i++) fold = fold ^ bus.q[i*32 +: 32];
  end

  // Outputs are computed from the next state and next LFSR value so that the
  // registered d/en/sr line up with the RUN cycle that holds that LFSR value.
  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    sig_d  = sig_q;
    cmp_d  = (state_q == RUN);
    if (state_d != state_q)                        cnt_d = '0;
    else if (state_q == SETTLE || state_q == RUN)  cnt_d = cnt_q + 32'd1;
    if (state_q == RUN) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (cmp_q) sig_d = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0)) ^ fold;
    if (start_ok) begin
      lfsr_d = SEED_EFF;
      sig_d  = '1;
    end
    en_d   = (state_d == RUN) && lfsr_d[0];
    sr_d   = (state_d == RUN) && lfsr_d[1] && lfsr_d[2];
    d_d    = (state_d == RUN) && lfsr_d[3];
    busy_d = (state_d == SETTLE) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
`ifdef SIG_COMPARE_EN
    pass_d = pass_q;
    if (start_ok)               pass_d = 1'b0;
    else if (state_q == DRAIN)  pass_d = (sig_d == GOLDEN);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lfsr_q <= SEED_EFF;
      sig_q  <= '0;
      cmp_q  <= 1'b0;
      d_q    <= 1'b0;
      en_q   <= 1'b0;
      sr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SIG_COMPARE_EN
      pass_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      sig_q  <= sig_d;
      cmp_q  <= cmp_d;
      d_q    <= d_d;
      en_q   <= en_d;
      sr_q   <= sr_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef SIG_COMPARE_EN
      pass_q <= pass_d;
`endif
    end
  end

  assign bus.d         = d_q;
  assign bus.en        = en_q;
  assign bus.sr        = sr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;
`ifdef SIG_COMPARE_EN
  assign bus.pass      = pass_q;
`endif

endmodule

// File: tb/tb_dff_stim_sig.sv
// Directed self-checking bench for dff_stim_sig: three instances cover
// single-step/fold, LFSR stimulus/robustness, and zero-seed behaviour.
module tb_dff_stim_sig;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic [2:0] exp1 [0:8];
  logic [2:0] exp2 [0:1];

  always #5 clk = ~clk;

  dff_stim_sig_if #(.WIDTH(64)) bus0 ();
  dff_stim_sig_if #(.WIDTH(64)) bus1 ();
  dff_stim_sig_if #(.WIDTH(64)) bus2 ();

  dff_stim_sig #(.WIDTH(64), .STEPS(1), .SETTLE_CYC(2), .SEED(16'hACE1), .POLY(32'h04C11DB7)
`ifdef SIG_COMPARE_EN
    , .GOLDEN(32'hFB3EE249)
`endif
  ) u0 (.clk(clk), .rst(rst), .bus(bus0));

  dff_stim_sig #(.WIDTH(64), .STEPS(12), .SETTLE_CYC(2), .SEED(16'hACE1), .POLY(32'h04C11DB7)
`ifdef SIG_COMPARE_EN
    , .GOLDEN(32'h0)
`endif
  ) u1 (.clk(clk), .rst(rst), .bus(bus1));

  dff_stim_sig #(.WIDTH(64), .STEPS(4), .SETTLE_CYC(1), .SEED(16'h0000), .POLY(32'h04C11DB7)
`ifdef SIG_COMPARE_EN
    , .GOLDEN(32'h0)
`endif
  ) u2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] misr_n(input logic [31:0] f, input int steps);
    logic [31:0] s;
    s = 32'hFFFFFFFF;
    for (int i = 0; i < steps; i++)
      s = ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ f;
    return s;
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  task automatic set_start(input int k, input logic v);
    case (k)
      0:       bus0.start = v;
      1:       bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  // Pulses start, then counts busy cycles (n=0 is the first SETTLE cycle).
  task automatic run_seq(input int k, input bit disturb, output int cnt);
    set_start(k, 1'b1);
    tick();
    set_start(k, 1'b0);
    cnt = 0;
    while (get_busy(k) && cnt < 40) begin
      if (k == 1 && (cnt == 0 || cnt == 14)) chk("idle_stim1", {61'h0, bus1.d, bus1.sr, bus1.en}, 64'h0);
      if (k == 1 && cnt >= 2 && cnt <= 10)
        chk($sformatf("stim1_%0d", cnt - 2), {61'h0, bus1.d, bus1.sr, bus1.en}, {61'h0, exp1[cnt-2]});
      if (k == 2 && cnt >= 1 && cnt <= 2)
        chk($sformatf("stim2_%0d", cnt - 1), {61'h0, bus2.d, bus2.sr, bus2.en}, {61'h0, exp2[cnt-1]});
      set_start(k, disturb && cnt == 6);
      cnt++;
      tick();
    end
    set_start(k, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {d, sr, en} for the first RUN cycles, hand-derived from the Galois LFSR.
    exp1 = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b110, 3'b011, 3'b001, 3'b101, 3'b000};
    exp2 = '{3'b001, 3'b000};
    rst = 1'b1;
    bus0.start = 1'b1; bus1.start = 1'b0; bus2.start = 1'b0;
    bus0.q = '0;
    bus1.q = 64'h1234_5678_9ABC_DEF0;
    bus2.q = 64'hFFFF_0000_0000_FFFF;

    tick(); tick();
    chk("rst_stim", {61'h0, bus0.d, bus0.en, bus0.sr}, 64'h0);
    chk("rst_busy", {63'h0, bus0.busy}, 64'h0);
    chk("rst_done", {63'h0, bus0.done}, 64'h0);
    chk("rst_sig",  {32'h0, bus0.signature}, 64'h0);
`ifdef SIG_COMPARE_EN
    chk("rst_pass", {63'h0, bus0.pass}, 64'h0);
`endif
    bus0.start = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_start_idle", {63'h0, bus0.busy}, 64'h0);

    run_seq(0, 1'b0, n);
    chk("single_busy_cycles", 64'(n), 64'd4);
    chk("single_done", {63'h0, bus0.done}, 64'h1);
    chk("single_sig", {32'h0, bus0.signature}, {32'h0, 32'hFB3EE249});
`ifdef SIG_COMPARE_EN
    chk("single_pass", {63'h0, bus0.pass}, 64'h1);
`endif
    tick();
    chk("done_held", {63'h0, bus0.done}, 64'h1);

    bus0.q = 64'h0000_0001_0000_0000;
    run_seq(0, 1'b0, n);
    chk("fold_hi_sig", {32'h0, bus0.signature}, {32'h0, 32'hFB3EE248});
`ifdef SIG_COMPARE_EN
    chk("fold_hi_pass", {63'h0, bus0.pass}, 64'h0);
`endif
    bus0.q = 64'h0000_0001_0000_0001;
    run_seq(0, 1'b0, n);
    chk("fold_cancel_sig", {32'h0, bus0.signature}, {32'h0, 32'hFB3EE249});

    run_seq(1, 1'b0, n);
    chk("run1_busy_cycles", 64'(n), 64'd15);
    chk("run1_done", {63'h0, bus1.done}, 64'h1);
    chk("run1_sig", {32'h0, bus1.signature}, {32'h0, misr_n(32'h88888888, 12)});

    run_seq(1, 1'b1, n);
    chk("disturb_busy_cycles", 64'(n), 64'd15);
    chk("disturb_sig", {32'h0, bus1.signature}, {32'h0, misr_n(32'h88888888, 12)});

    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    repeat (5) tick();
    chk("mid_run_busy", {63'h0, bus1.busy}, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_stim", {61'h0, bus1.d, bus1.en, bus1.sr}, 64'h0);
    chk("midrst_busy", {63'h0, bus1.busy}, 64'h0);
    chk("midrst_done", {63'h0, bus1.done}, 64'h0);
    chk("midrst_sig",  {32'h0, bus1.signature}, 64'h0);
    tick();
    chk("midrst_idle_done", {63'h0, bus1.done}, 64'h0);
    run_seq(1, 1'b0, n);
    chk("after_rst_busy_cycles", 64'(n), 64'd15);
    chk("after_rst_sig", {32'h0, bus1.signature}, {32'h0, misr_n(32'h88888888, 12)});

    run_seq(2, 1'b0, n);
    chk("seed0_busy_cycles", 64'(n), 64'd6);
    chk("seed0_sig", {32'h0, bus2.signature}, {32'h0, misr_n(32'hFFFFFFFF, 4)});
`ifdef SIG_COMPARE_EN
    chk("seed0_pass", {63'h0, bus2.pass}, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
